// File: rtl/bip_tx_dump.sv
// Snapshots ACC, PC and the pre-halt cycle count when the BIP halts, then
// streams them to uart_tx as three little-endian words over the start/done handshake.
module bip_tx_dump #(
   parameter int NBITS_D = 16,
   parameter int NBITS_O = 11,
   parameter int DBIT    = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_halt,
   input  logic [NBITS_D-1:0] i_acc,
   input  logic [NBITS_O-1:0] i_pc,
   output logic               o_tx_start,
   output logic [DBIT-1:0]    o_tx_data,
   input  logic               i_tx_done,
   output logic               o_busy,
   output logic               o_done
);

   localparam int NWORDS = 3;
   localparam int NBYTES = 2 * NWORDS;
   localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

   state_t             state_reg;
   logic [2:0]         index_reg;
   logic [NBITS_D-1:0] cyc_reg;
   logic [DBIT-1:0]    frame_reg [NBYTES];
   logic               tx_start_reg;
   logic               busy_reg;
   logic               done_reg;

   logic [NBITS_D-1:0] snap_words    [NWORDS];
   logic [DBIT-1:0]    capture_bytes [NBYTES];

   assign snap_words[0] = i_acc;
   assign snap_words[1] = {{(NBITS_D - NBITS_O){1'b0}}, i_pc};
   assign snap_words[2] = cyc_reg;

   // Each word goes out low byte first.
   generate
      for (genvar gi = 0; gi < NWORDS; gi++) begin : g_split
         assign capture_bytes[2*gi]   = snap_words[gi][DBIT-1:0];
         assign capture_bytes[2*gi+1] = snap_words[gi][2*DBIT-1:DBIT];
      end
   endgenerate

   // Run-length counter: only advances while running, sticks at all-ones.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cyc_reg <= '0;
      end else if (state_reg == IDLE && !i_halt && cyc_reg != '1) begin
         cyc_reg <= cyc_reg + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg    <= IDLE;
         index_reg    <= '0;
         tx_start_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         for (int i = 0; i < NBYTES; i++) begin
            frame_reg[i] <= '0;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_halt) begin
                  for (int i = 0; i < NBYTES; i++) begin
                     frame_reg[i] <= capture_bytes[i];
                  end
                  index_reg    <= '0;
                  state_reg    <= SEND;
                  tx_start_reg <= 1'b1;
                  busy_reg     <= 1'b1;
               end
            end
            SEND: begin
               // A done tick here belongs to no byte of ours and is dropped.
               state_reg    <= WAIT;
               tx_start_reg <= 1'b0;
            end
            WAIT: begin
               if (i_tx_done) begin
                  if (index_reg == LAST_IDX) begin
                     state_reg <= DONE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                  end else begin
                     index_reg    <= index_reg + 1'b1;
                     state_reg    <= SEND;
                     tx_start_reg <= 1'b1;
                  end
               end
            end
            DONE: begin
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign o_tx_start = tx_start_reg;
   assign o_tx_data  = frame_reg[index_reg];
   assign o_busy     = busy_reg;
   assign o_done     = done_reg;

endmodule
